// File: rtl/dft_frame_pkg.sv
// Shared definitions for the DFT request frame path (serializer and processor).
// Contents: minimum legal nfft, header byte field positions, bytes per complex
// sample, the frame state encoding and a header builder.
package dft_frame_pkg;

   localparam int NFFT_MIN         = 3;
   localparam int HDR_NFFT_LSB     = 0;
   localparam int HDR_NFFT_W       = 5;
   localparam int HDR_INV_BIT      = 5;
   localparam int BYTES_PER_SAMPLE = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FETCH,
      ST_WAIT_RD,
      ST_SEND,
      ST_STROBE,
      ST_GAP,
      ST_DONE
   } state_e;

   // Header byte: {2'b00, inverse, nfft[4:0]}
   function automatic logic [7:0] make_header(input logic inv, input logic [4:0] nfft);
      logic [7:0] h;
      h = '0;
      h[HDR_NFFT_LSB +: HDR_NFFT_W] = nfft;
      h[HDR_INV_BIT]                = inv;
      return h;
   endfunction

endpackage

// File: rtl/dft_frame_tx_byte_strobe_gen.sv
// byte_strobe_gen: per-byte SEND/STROBE/GAP timer.
// Ports:
//   i_Clock, i_Reset_n  clock, async active-low reset
//   i_Go                start a byte (accepted when idle or on the last gap cycle)
//   i_ReadyForOutput    downstream level handshake, looked at only in SEND
//   o_ByteReady         registered strobe, high STROBE_CYCLES cycles
//   o_ByteDone          1-cycle pulse on the last gap cycle of a byte
module byte_strobe_gen
   import dft_frame_pkg::*;
#(
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 2
) (
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic i_Go,
   input  logic i_ReadyForOutput,
   output logic o_ByteReady,
   output logic o_ByteDone
);

   localparam int MAXC  = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               strobe_q;

   assign o_ByteReady = strobe_q;
   assign o_ByteDone  = (state_q == ST_GAP) && (cnt_q == CNT_W'(GAP_CYCLES - 1));

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_Go) state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (i_ReadyForOutput) begin
                  strobe_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                  strobe_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (o_ByteDone) begin
                  cnt_q <= '0;
                  // Back-to-back bytes skip IDLE so the period stays 1+S+G.
                  state_q <= i_Go ? ST_SEND : ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               strobe_q <= 1'b0;
               cnt_q    <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dft_frame_tx.sv
// dft_frame_tx: reads 2^nfft complex samples from a sample RAM and emits one
// DFT request frame (header + 8 bytes per sample, LSB first) on a byte strobe.
// Ports:
//   i_Clock, i_Reset_n           clock, async active-low reset
//   i_Start, i_Nfft, i_Inverse   frame request (sampled on i_Start when idle)
//   o_SampleAddr                 RAM read address, data returns one cycle later
//   i_SampleRe, i_SampleIm       RAM read data
//   i_ReadyForOutput             downstream level handshake
//   o_ByteReady, o_Byte          byte strobe and data
//   o_Busy, o_Done, o_Error      frame status
module dft_frame_tx
   import dft_frame_pkg::*;
#(
   parameter int ADDR_W        = 10,
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 2
) (
   input  logic              i_Clock,
   input  logic              i_Reset_n,
   input  logic              i_Start,
   input  logic [4:0]        i_Nfft,
   input  logic              i_Inverse,
   output logic [ADDR_W-1:0] o_SampleAddr,
   input  logic [31:0]       i_SampleRe,
   input  logic [31:0]       i_SampleIm,
   input  logic              i_ReadyForOutput,
   output logic              o_ByteReady,
   output logic [7:0]        o_Byte,
   output logic              o_Busy,
   output logic              o_Done,
   output logic              o_Error
);

   localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_SAMPLE - 1);

   state_e            state_q;
   logic [4:0]        nfft_q;
   logic [ADDR_W-1:0] sample_cnt_q;
   logic [ADDR_W-1:0] sample_cnt_d;
   logic [2:0]        byte_idx_q;
   logic [55:0]       shift_q;     // sample bytes not yet on o_Byte
   logic [7:0]        byte_q;
   logic [ADDR_W-1:0] addr_q;
   logic              busy_q, done_q, err_q;

   logic              nfft_legal;
   logic              go;
   logic              byte_done;
   logic [ADDR_W:0]   last_idx;
   logic              last_sample;

   assign o_SampleAddr = addr_q;
   assign o_Byte       = byte_q;
   assign o_Busy       = busy_q;
   assign o_Done       = done_q;
   assign o_Error      = err_q;

   assign nfft_legal   = (int'(i_Nfft) >= NFFT_MIN) && (int'(i_Nfft) <= ADDR_W);
   // One bit wider than the address so nfft==ADDR_W does not wrap.
   assign last_idx     = ((ADDR_W + 1)'(1) << nfft_q) - (ADDR_W + 1)'(1);
   assign last_sample  = ({1'b0, sample_cnt_q} == last_idx);
   assign sample_cnt_d = sample_cnt_q + ADDR_W'(1);

   // Byte launch: first header byte, each freshly fetched sample, and every
   // further byte of the current sample on the last gap cycle.
   assign go = ((state_q == ST_IDLE) && i_Start && nfft_legal) ||
               (state_q == ST_WAIT_RD) ||
               ((state_q == ST_SEND) && byte_done && (byte_idx_q != LAST_BYTE));

   byte_strobe_gen #(
      .STROBE_CYCLES (STROBE_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES)
   ) u_strobe (
      .i_Clock          (i_Clock),
      .i_Reset_n        (i_Reset_n),
      .i_Go             (go),
      .i_ReadyForOutput (i_ReadyForOutput),
      .o_ByteReady      (o_ByteReady),
      .o_ByteDone       (byte_done)
   );

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q      <= ST_IDLE;
         nfft_q       <= '0;
         sample_cnt_q <= '0;
         byte_idx_q   <= '0;
         shift_q      <= '0;
         byte_q       <= '0;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_Start) begin
                  if (nfft_legal) begin
                     // Inverse flag lives only in the header byte.
                     nfft_q       <= i_Nfft;
                     sample_cnt_q <= '0;
                     byte_idx_q   <= '0;
                     byte_q       <= make_header(i_Inverse, i_Nfft);
                     busy_q       <= 1'b1;
                     state_q      <= ST_HDR;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_HDR: begin
               if (byte_done) begin
                  // Address is presented during FETCH so data lands in WAIT_RD.
                  addr_q  <= sample_cnt_q;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state_q <= ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
               shift_q    <= {i_SampleIm, i_SampleRe[31:8]};
               byte_q     <= i_SampleRe[7:0];
               byte_idx_q <= '0;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               if (byte_done) begin
                  if (byte_idx_q != LAST_BYTE) begin
                     byte_idx_q <= byte_idx_q + 3'd1;
                     byte_q     <= shift_q[7:0];
                     shift_q    <= {8'h00, shift_q[55:8]};
                  end else if (last_sample) begin
                     state_q <= ST_DONE;
                  end else begin
                     sample_cnt_q <= sample_cnt_d;
                     addr_q       <= sample_cnt_d;
                     state_q      <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
